axi_lite_reg_bridge: RTL and testbench
======================================

# axi_lite_reg_bridge

Terminates an AXI-Lite channel and converts each transaction into a single request on a simple valid/ready register bus, plus one response. It sits directly downstream of an `axi_lite_buf` slave port, in front of peripheral register files. It keeps exactly one transaction outstanding and arbitrates reads against writes round-robin. A response timeout returns SLVERR if the register target never answers.

## Interface

- `ADDR_WIDTH`, default 48: address width; must equal `host.ADDR_WIDTH`, otherwise `$fatal`.
- `DATA_WIDTH`, default 64: data width; must equal `host.DATA_WIDTH`, otherwise `$fatal`.
- `TIMEOUT`, default 1024: maximum WAIT-state cycles before a forced SLVERR; 0 disables the timeout.
- `host.clk`, input, 1: single clock for all logic, carried by the interface.
- `host.rstn`, input, 1: reset, synchronous and active-low, carried by the interface.
- `host`, `axi_lite_channel.slave`, —: AW, W, B, AR and R channels, using the `prot_t` and `resp_t` types from `axi_common`.
- `reg_req_valid`, output, 1: request valid.
- `reg_req_ready`, input, 1: target accepts the request.
- `reg_req_write`, output, 1: 1 = write, 0 = read.
- `reg_req_addr`, output, ADDR_WIDTH: latched AW or AR address.
- `reg_req_wdata`, output, DATA_WIDTH: latched W data; 0 for reads.
- `reg_req_wstrb`, output, DATA_WIDTH/8: latched W strobe; 0 for reads.
- `reg_rsp_valid`, input, 1: one-cycle response pulse. There is no ready; the bridge always sinks it in WAIT.
- `reg_rsp_rdata`, input, DATA_WIDTH: read data; ignored for writes.
- `reg_rsp_error`, input, 1: 1 maps to SLVERR (2'b10); 0 maps to OKAY (2'b00).

## Operation

- **FSM states:** IDLE, REQ, WAIT, BRESP, RRESP.
- **IDLE:**
  - A write is pending when `aw_valid && w_valid`; a read is pending when `ar_valid`.
  - If only one kind is pending, grant it.
  - If both are pending, grant the opposite of `last_grant`. `last_grant` resets to "write", so a read wins the first tie.
  - Write grant: `aw_ready` and `w_ready` are both 1 in the same cycle. Latch addr, data and strb, set `reg_req_write` = 1, go to REQ.
  - Read grant: `ar_ready` = 1. Latch addr, set wdata/strb = 0, go to REQ.
  - AW is never accepted without W, and W never without AW.
  - `aw_ready`, `w_ready` and `ar_ready` are 0 in every state other than IDLE.
- **REQ:**
  - `reg_req_valid` = 1. All `reg_req_*` fields are held stable until `reg_req_ready`.
  - On the handshake, go to WAIT. `reg_req_valid` must not drop before the handshake; the timeout does not apply in REQ.
- **WAIT:**
  - `reg_rsp_valid` latches the error and, for reads, rdata. Go to BRESP for a write, RRESP for a read.
  - A timeout counter clears on WAIT entry and increments each WAIT cycle without a response.
  - When the counter reaches `TIMEOUT`-1 with no response, latch error = 1 and rdata = 0, then go to BRESP or RRESP.
  - `reg_rsp_valid` in any state other than WAIT is ignored. This covers late responses after a timeout.
- **BRESP:**
  - `b_valid` = 1 and `b_resp` = latched code.
  - On `b_ready`, go to IDLE.
- **RRESP:**
  - `r_valid` = 1, `r_data` = latched rdata, `r_resp` = latched code.
  - On `r_ready`, go to IDLE.
- **`last_grant`:** updated on every grant.
- **`prot`:** accepted and discarded.

## Timing

- **Reset** (`rstn` = 0 at a rising edge):
  - State goes to IDLE; `last_grant` and the timeout counter reset.
  - All valids and readies are 0 in the cycle after reset, except the IDLE readies, which follow the pending inputs combinationally.
  - `b_resp`, `r_resp`, `r_data` and all `reg_req_*` data fields reset to 0.
- **Reset mid-transaction:** the transaction is abandoned with no B or R issued, and any response arriving after reset is ignored.
- **Minimum write latency:**
  - AW/W handshake at cycle 0.
  - `reg_req_valid` in cycle 1, with `ready` = 1.
  - `reg_rsp_valid` in cycle 2.
  - `b_valid` in cycle 3.
  - Next AW/W/AR acceptance possible in cycle 4 if `b_ready` was 1 in cycle 3.
- **Minimum read latency:** the same sequence, with `r_valid` in cycle 3.
- **Throughput:** at most one transaction per 4 cycles.
- **Combinational paths:** IDLE readies depend combinationally on `aw_valid`, `w_valid`, `ar_valid` and `last_grant`. There are no other input-to-output combinational paths; all other outputs are registered or decoded from the state.
- **Timeout arithmetic:**
  - The counter is `$clog2(TIMEOUT+1)` bits and never wraps.
  - With `TIMEOUT` = N, the forced response occurs N cycles after WAIT entry.
  - `TIMEOUT` = 0 removes the counter.

## Test plan

- **Single write:** AW addr 0x1000, W data 0xDEADBEEF, strb 0xFF, with target ready = 1 and rsp one cycle later with error = 0.
  - `reg_req_write` = 1, addr = 0x1000.
  - `b_resp` = 2'b00 at cycle 3.
- **Single read with error:** AR addr 0x2008, rsp rdata = 0x1234, error = 1.
  - `r_data` = 0x1234, `r_resp` = 2'b10.
- **Simultaneous AW+W and AR, repeated 4 times after reset:** grants alternate read, write, read, write. No AW/W is accepted without the other.
- **Backpressure:**
  - `reg_req_ready` held 0 for 5 cycles: `reg_req_*` stays stable and valid throughout.
  - `b_ready` held 0 for 3 cycles: `b_valid` and `b_resp` stay stable, and no AR is accepted meanwhile.
- **Timeout:** `TIMEOUT` = 8 and no response.
  - `r_valid` with `r_resp` = 2'b10 and `r_data` = 0 exactly 8 cycles after WAIT entry.
  - A late `reg_rsp_valid` afterwards is ignored.
- **Reset during WAIT:** all outputs return to reset values, with no B or R issued. A subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI-Lite channel bundle shared between the upstream buffer and the register bridge.
// The common AXI types live alongside it so both ends agree on encodings.
package axi_common;
  typedef logic [2:0] prot_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RespOkay   = 2'b00;
  localparam resp_t RespSlvErr = 2'b10;
endpackage

interface axi_lite_channel #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);
  import axi_common::*;

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  prot_t                   aw_prot;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;

  logic                    b_valid;
  logic                    b_ready;
  resp_t                   b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  prot_t                   ar_prot;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot,
    output w_valid, w_data, w_strb,
    output b_ready,
    output ar_valid, ar_addr, ar_prot,
    output r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot,
    input  w_valid, w_data, w_strb,
    input  b_ready,
    input  ar_valid, ar_addr, ar_prot,
    input  r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave to single-outstanding valid/ready register bus bridge with
// round-robin read/write arbitration and a response timeout.
module axi_lite_reg_bridge #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT    = 1024
) (
  axi_lite_channel.slave          host,

  output logic                    reg_req_valid,
  input  logic                    reg_req_ready,
  output logic                    reg_req_write,
  output logic [ADDR_WIDTH-1:0]   reg_req_addr,
  output logic [DATA_WIDTH-1:0]   reg_req_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_req_wstrb,

  input  logic                    reg_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   reg_rsp_rdata,
  input  logic                    reg_rsp_error
);
  import axi_common::*;

  if ($bits(host.aw_addr) != ADDR_WIDTH) begin : g_addr_width_check
    $fatal(1, "axi_lite_reg_bridge: ADDR_WIDTH does not match host interface");
  end
  if ($bits(host.w_data) != DATA_WIDTH) begin : g_data_width_check
    $fatal(1, "axi_lite_reg_bridge: DATA_WIDTH does not match host interface");
  end

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StBresp,
    StRresp
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic                    req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_WIDTH/8-1:0] req_wstrb_q, req_wstrb_d;
  resp_t                   resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic wr_pend, rd_pend;
  logic grant_wr, grant_rd;
  logic timeout_hit;

  // Protection bits carry no meaning for the register targets.
  logic unused_prot;
  assign unused_prot = ^{host.aw_prot, host.ar_prot};

  // AW and W are only ever accepted together; on a tie the side not granted last wins.
  assign wr_pend  = host.aw_valid & host.w_valid;
  assign rd_pend  = host.ar_valid;
  assign grant_wr = (state_q == StIdle) & wr_pend & (~rd_pend | ~last_wr_q);
  assign grant_rd = (state_q == StIdle) & rd_pend & (~wr_pend | last_wr_q);

  assign host.aw_ready = grant_wr;
  assign host.w_ready  = grant_wr;
  assign host.ar_ready = grant_rd;

  assign host.b_valid = (state_q == StBresp);
  assign host.b_resp  = resp_q;
  assign host.r_valid = (state_q == StRresp);
  assign host.r_resp  = resp_q;
  assign host.r_data  = rdata_q;

  assign reg_req_valid = (state_q == StReq);
  assign reg_req_write = req_write_q;
  assign reg_req_addr  = req_addr_q;
  assign reg_req_wdata = req_wdata_q;
  assign reg_req_wstrb = req_wstrb_q;

  if (TIMEOUT > 0) begin : g_timeout
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

    // Held at zero outside WAIT, so it is already clear on WAIT entry.
    always_ff @(posedge host.clk) begin
      if (!host.rstn) begin
        cnt_q <= '0;
      end else if (state_q != StWait) begin
        cnt_q <= '0;
      end else if (!reg_rsp_valid && !timeout_hit) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          state_d     = StReq;
          last_wr_d   = 1'b1;
          req_write_d = 1'b1;
          req_addr_d  = host.aw_addr;
          req_wdata_d = host.w_data;
          req_wstrb_d = host.w_strb;
        end else if (grant_rd) begin
          state_d     = StReq;
          last_wr_d   = 1'b0;
          req_write_d = 1'b0;
          req_addr_d  = host.ar_addr;
          req_wdata_d = '0;
          req_wstrb_d = '0;
        end
      end
      StReq: begin
        if (reg_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (reg_rsp_valid) begin
          resp_d  = reg_rsp_error ? RespSlvErr : RespOkay;
          if (!req_write_q) begin
            rdata_d = reg_rsp_rdata;
          end
          state_d = req_write_q ? StBresp : StRresp;
        end else if (timeout_hit) begin
          resp_d  = RespSlvErr;
          rdata_d = '0;
          state_d = req_write_q ? StBresp : StRresp;
        end
      end
      StBresp: begin
        if (host.b_ready) begin
          state_d = StIdle;
        end
      end
      StRresp: begin
        if (host.r_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge host.clk) begin
    if (!host.rstn) begin
      state_q     <= StIdle;
      last_wr_q   <= 1'b1;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      resp_q      <= RespOkay;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge: inputs change and outputs are sampled
// on the falling edge; the design acts on the rising edge.
module tb_axi_lite_reg_bridge;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host (.clk(clk), .rstn(rstn));

  logic          reg_req_valid;
  logic          reg_req_ready;
  logic          reg_req_write;
  logic [AW-1:0] reg_req_addr;
  logic [DW-1:0] reg_req_wdata;
  logic [DW/8-1:0] reg_req_wstrb;
  logic          reg_rsp_valid;
  logic [DW-1:0] reg_rsp_rdata;
  logic          reg_rsp_error;

  int checks = 0;
  int failures = 0;

  axi_lite_reg_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (8)
  ) dut (
    .host         (host),
    .reg_req_valid(reg_req_valid),
    .reg_req_ready(reg_req_ready),
    .reg_req_write(reg_req_write),
    .reg_req_addr (reg_req_addr),
    .reg_req_wdata(reg_req_wdata),
    .reg_req_wstrb(reg_req_wstrb),
    .reg_rsp_valid(reg_rsp_valid),
    .reg_rsp_rdata(reg_rsp_rdata),
    .reg_rsp_error(reg_rsp_error)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    host.aw_valid = 1'b0; host.aw_addr = '0; host.aw_prot = 3'b000;
    host.w_valid  = 1'b0; host.w_data  = '0; host.w_strb  = '0;
    host.b_ready  = 1'b0;
    host.ar_valid = 1'b0; host.ar_addr = '0; host.ar_prot = 3'b000;
    host.r_ready  = 1'b0;
    reg_req_ready = 1'b0;
    reg_rsp_valid = 1'b0; reg_rsp_rdata = '0; reg_rsp_error = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({host.b_valid, host.r_valid, reg_req_valid, host.aw_ready, host.w_ready,
         host.ar_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=%b", {host.b_valid, host.r_valid,
               reg_req_valid, host.aw_ready, host.w_ready, host.ar_ready}, 6'b0);
    end
    checks++;
    if ({host.b_resp, host.r_resp, reg_req_write} !== 5'b0 || host.r_data !== '0 ||
        reg_req_addr !== '0 || reg_req_wdata !== '0 || reg_req_wstrb !== '0) begin
      failures++;
      $display("FAIL reset_data got bresp=%0h rresp=%0h rdata=%0h addr=%0h exp all 0",
               host.b_resp, host.r_resp, host.r_data, reg_req_addr);
    end
    host.ar_valid = 1'b1;
    #1;
    checks++;
    if (host.ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_arready got=%b exp=1", host.ar_ready);
    end
    host.ar_valid = 1'b0;
  endtask

  task automatic test_single_write();
    host.aw_valid = 1'b1; host.aw_addr = 48'h1000;
    host.w_valid  = 1'b1; host.w_data  = 64'hDEADBEEF; host.w_strb = 8'hFF;
    reg_req_ready = 1'b1; host.b_ready = 1'b1;
    #1;
    checks++;
    if ({host.aw_ready, host.w_ready, host.ar_ready} !== 3'b110) begin
      failures++;
      $display("FAIL wr_grant got=%b exp=110", {host.aw_ready, host.w_ready, host.ar_ready});
    end
    tick();  // cycle 1
    host.aw_valid = 1'b0; host.w_valid = 1'b0;
    checks++;
    if ({reg_req_valid, reg_req_write} !== 2'b11 || reg_req_addr !== 48'h1000 ||
        reg_req_wdata !== 64'hDEADBEEF || reg_req_wstrb !== 8'hFF) begin
      failures++;
      $display("FAIL wr_req got v=%b w=%b a=%0h d=%0h s=%0h exp 1 1 1000 deadbeef ff",
               reg_req_valid, reg_req_write, reg_req_addr, reg_req_wdata, reg_req_wstrb);
    end
    tick();  // cycle 2
    reg_rsp_valid = 1'b1; reg_rsp_error = 1'b0;
    tick();  // cycle 3
    reg_rsp_valid = 1'b0;
    checks++;
    if (host.b_valid !== 1'b1 || host.b_resp !== 2'b00) begin
      failures++;
      $display("FAIL wr_bresp got valid=%b resp=%b exp 1 00", host.b_valid, host.b_resp);
    end
    tick();  // cycle 4
    checks++;
    if (host.b_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_bdone got=%b exp=0", host.b_valid);
    end
  endtask

  task automatic test_single_read_error();
    host.ar_valid = 1'b1; host.ar_addr = 48'h2008;
    reg_req_ready = 1'b1; host.r_ready = 1'b1;
    #1;
    checks++;
    if ({host.aw_ready, host.ar_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_grant got=%b exp=01", {host.aw_ready, host.ar_ready});
    end
    tick();
    host.ar_valid = 1'b0;
    checks++;
    if ({reg_req_valid, reg_req_write} !== 2'b10 || reg_req_addr !== 48'h2008 ||
        reg_req_wdata !== '0 || reg_req_wstrb !== '0) begin
      failures++;
      $display("FAIL rd_req got v=%b w=%b a=%0h d=%0h s=%0h exp 1 0 2008 0 0",
               reg_req_valid, reg_req_write, reg_req_addr, reg_req_wdata, reg_req_wstrb);
    end
    tick();
    reg_rsp_valid = 1'b1; reg_rsp_rdata = 64'h1234; reg_rsp_error = 1'b1;
    tick();
    reg_rsp_valid = 1'b0; reg_rsp_error = 1'b0;
    checks++;
    if (host.r_valid !== 1'b1 || host.r_data !== 64'h1234 || host.r_resp !== 2'b10) begin
      failures++;
      $display("FAIL rd_rresp got valid=%b data=%0h resp=%b exp 1 1234 10",
               host.r_valid, host.r_data, host.r_resp);
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic exp_wr;
    do_reset();
    reg_req_ready = 1'b1; host.b_ready = 1'b1; host.r_ready = 1'b1;
    host.aw_valid = 1'b1; host.aw_addr = 48'h100;
    host.w_valid  = 1'b1; host.w_data  = 64'h55; host.w_strb = 8'h03;
    host.ar_valid = 1'b1; host.ar_addr = 48'h200;
    for (int i = 0; i < 4; i++) begin
      exp_wr = (i % 2) == 1;
      #1;
      checks++;
      if ({host.aw_ready, host.w_ready, host.ar_ready} !== (exp_wr ? 3'b110 : 3'b001)) begin
        failures++;
        $display("FAIL arb_grant%0d got=%b exp=%b", i,
                 {host.aw_ready, host.w_ready, host.ar_ready}, exp_wr ? 3'b110 : 3'b001);
      end
      tick();
      checks++;
      if (reg_req_write !== exp_wr || reg_req_addr !== (exp_wr ? 48'h100 : 48'h200) ||
          {host.aw_ready, host.w_ready, host.ar_ready} !== 3'b000) begin
        failures++;
        $display("FAIL arb_req%0d got w=%b a=%0h rdy=%b exp w=%b", i, reg_req_write,
                 reg_req_addr, {host.aw_ready, host.w_ready, host.ar_ready}, exp_wr);
      end
      tick();
      reg_rsp_valid = 1'b1;
      tick();
      reg_rsp_valid = 1'b0;
      checks++;
      if ({host.b_valid, host.r_valid} !== (exp_wr ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL arb_resp%0d got=%b exp=%b", i, {host.b_valid, host.r_valid},
                 exp_wr ? 2'b10 : 2'b01);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    host.aw_valid = 1'b1; host.aw_addr = 48'h3000;
    host.w_valid  = 1'b1; host.w_data  = 64'h0123456789ABCDEF; host.w_strb = 8'h0F;
    reg_req_ready = 1'b0; host.b_ready = 1'b0;
    tick();
    host.aw_valid = 1'b0; host.w_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({reg_req_valid, reg_req_write} !== 2'b11 || reg_req_addr !== 48'h3000 ||
          reg_req_wdata !== 64'h0123456789ABCDEF || reg_req_wstrb !== 8'h0F) begin
        failures++;
        $display("FAIL bp_req_hold%0d got v=%b a=%0h d=%0h s=%0h", k, reg_req_valid,
                 reg_req_addr, reg_req_wdata, reg_req_wstrb);
      end
      tick();
    end
    reg_req_ready = 1'b1;
    tick();
    reg_req_ready = 1'b0;
    reg_rsp_valid = 1'b1; reg_rsp_error = 1'b1;
    tick();
    reg_rsp_valid = 1'b0; reg_rsp_error = 1'b0;
    host.ar_valid = 1'b1; host.ar_addr = 48'h3100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (host.b_valid !== 1'b1 || host.b_resp !== 2'b10 || host.ar_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_b_hold%0d got valid=%b resp=%b arready=%b exp 1 10 0", k,
                 host.b_valid, host.b_resp, host.ar_ready);
      end
      tick();
    end
    host.b_ready = 1'b1;
    tick();
    host.b_ready = 1'b0;
    #1;
    checks++;
    if (host.ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ar_after got=%b exp=1", host.ar_ready);
    end
    reg_req_ready = 1'b1; host.r_ready = 1'b1;
    tick();
    host.ar_valid = 1'b0;
    tick();
    reg_rsp_valid = 1'b1; reg_rsp_rdata = 64'h5555;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if (host.r_valid !== 1'b1 || host.r_data !== 64'h5555 || host.r_resp !== 2'b00) begin
      failures++;
      $display("FAIL bp_read got valid=%b data=%0h resp=%b exp 1 5555 00",
               host.r_valid, host.r_data, host.r_resp);
    end
    tick();
  endtask

  task automatic test_timeout();
    host.ar_valid = 1'b1; host.ar_addr = 48'h4000;
    reg_req_ready = 1'b1; host.r_ready = 1'b0;
    tick();  // cycle 1
    host.ar_valid = 1'b0;
    tick();  // cycle 2: first WAIT cycle
    for (int k = 2; k < 10; k++) begin
      checks++;
      if (host.r_valid !== 1'b0) begin
        failures++;
        $display("FAIL to_early cycle%0d got=%b exp=0", k, host.r_valid);
      end
      tick();
    end
    checks++;
    if (host.r_valid !== 1'b1 || host.r_resp !== 2'b10 || host.r_data !== '0) begin
      failures++;
      $display("FAIL to_resp got valid=%b resp=%b data=%0h exp 1 10 0",
               host.r_valid, host.r_resp, host.r_data);
    end
    reg_rsp_valid = 1'b1; reg_rsp_rdata = 64'hBEEF; reg_rsp_error = 1'b0;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if (host.r_valid !== 1'b1 || host.r_resp !== 2'b10 || host.r_data !== '0) begin
      failures++;
      $display("FAIL to_late got valid=%b resp=%b data=%0h exp 1 10 0",
               host.r_valid, host.r_resp, host.r_data);
    end
    host.r_ready = 1'b1;
    tick();
    checks++;
    if (host.r_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_done got=%b exp=0", host.r_valid);
    end
  endtask

  task automatic test_reset_wait();
    host.aw_valid = 1'b1; host.aw_addr = 48'h6000;
    host.w_valid  = 1'b1; host.w_data  = 64'h77; host.w_strb = 8'h01;
    reg_req_ready = 1'b1; host.b_ready = 1'b1; host.r_ready = 1'b1;
    tick();
    host.aw_valid = 1'b0; host.w_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    reg_rsp_valid = 1'b1; reg_rsp_error = 1'b1; reg_rsp_rdata = 64'h99;
    checks++;
    if ({host.b_valid, host.r_valid, reg_req_valid, reg_req_write} !== 4'b0 ||
        {host.b_resp, host.r_resp} !== 4'b0 || host.r_data !== '0 ||
        reg_req_addr !== '0 || reg_req_wdata !== '0 || reg_req_wstrb !== '0) begin
      failures++;
      $display("FAIL rstw_outputs got bv=%b rv=%b qv=%b a=%0h d=%0h s=%0h exp all 0",
               host.b_valid, host.r_valid, reg_req_valid, reg_req_addr, reg_req_wdata,
               reg_req_wstrb);
    end
    tick();
    reg_rsp_valid = 1'b0; reg_rsp_error = 1'b0;
    checks++;
    if ({host.b_valid, host.r_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rstw_no_resp got=%b exp=00", {host.b_valid, host.r_valid});
    end
    host.ar_valid = 1'b1; host.ar_addr = 48'h5010;
    tick();
    host.ar_valid = 1'b0;
    checks++;
    if ({reg_req_valid, reg_req_write} !== 2'b10 || reg_req_addr !== 48'h5010) begin
      failures++;
      $display("FAIL rstw_read_req got v=%b w=%b a=%0h exp 1 0 5010",
               reg_req_valid, reg_req_write, reg_req_addr);
    end
    tick();
    reg_rsp_valid = 1'b1; reg_rsp_rdata = 64'hCAFE;
    tick();
    reg_rsp_valid = 1'b0;
    checks++;
    if (host.r_valid !== 1'b1 || host.r_data !== 64'hCAFE || host.r_resp !== 2'b00) begin
      failures++;
      $display("FAIL rstw_read got valid=%b data=%0h resp=%b exp 1 cafe 00",
               host.r_valid, host.r_data, host.r_resp);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_single_read_error();
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
